// File: rtl/colour_picker.sv
// Eyedropper: reads the canvas pixel under the cursor and matches it against the fixed
// 13-entry palette, one compare per cycle, reporting the index of the first exact match.
module colour_picker #(
  parameter int LOCKOUT_CYCLES = 25000000,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int WIDTH          = 96,
  parameter int HEIGHT         = 64
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        en,
  input  logic        pick_btn,
  input  logic [6:0]  cursor_x,
  input  logic [5:0]  cursor_y,
  output logic        fb_rd_en,
  output logic [12:0] fb_rd_addr,
  input  logic [15:0] fb_rd_data,
  input  logic        fb_rd_valid,
  output logic        busy,
  output logic        pick_done,
  output logic        pick_miss,
  output logic [3:0]  picked_index,
  output logic [15:0] picked_colour
);

  localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LK_W-1:0] LK_LAST  = LK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      X_LIM    = 8'(WIDTH);
  localparam logic [6:0]      Y_LIM    = 7'(HEIGHT);
  localparam logic [3:0]      LAST_IDX = 4'd12;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SCAN, DONE, LOCKOUT} state_t;

  state_t            state, state_nxt;
  logic              btn_prev;
  logic              miss;
  logic [3:0]        k;
  logic [15:0]       pixel;
  logic [TO_W-1:0]   tmo_cnt;
  logic [LK_W-1:0]   lk_cnt;
  logic              trig;
  logic              in_range;
  logic              hit;
  logic [12:0]       addr_calc;

  function automatic logic [15:0] palette(input logic [3:0] idx);
    case (idx)
      4'd0:    palette = 16'h0000;
      4'd1:    palette = 16'hFED3;
      4'd2:    palette = 16'hFD46;
      4'd3:    palette = 16'hC240;
      4'd4:    palette = 16'hF800;
      4'd5:    palette = 16'hCB5D;
      4'd6:    palette = 16'h1619;
      4'd7:    palette = 16'h2B58;
      4'd8:    palette = 16'h0C8A;
      4'd9:    palette = 16'h7687;
      4'd10:   palette = 16'hFFCB;
      4'd11:   palette = 16'h3FCF;
      4'd12:   palette = 16'hC618;
      default: palette = 16'h0000;
    endcase
  endfunction

  assign trig      = en && pick_btn && !btn_prev;
  assign in_range  = ({1'b0, cursor_x} < X_LIM) && ({1'b0, cursor_y} < Y_LIM);
  assign addr_calc = 13'(cursor_y) * 13'(WIDTH) + 13'(cursor_x);
  assign hit       = (pixel == palette(k));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fb_rd_en  = 1'b0;
    pick_done = 1'b0;
    pick_miss = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (trig) state_nxt = in_range ? REQ : DONE;
      REQ: begin
        fb_rd_en  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (fb_rd_valid)             state_nxt = SCAN;
        else if (tmo_cnt == TO_LAST) state_nxt = DONE;
      end
      SCAN:    if (hit || k == LAST_IDX) state_nxt = DONE;
      DONE: begin
        pick_done = 1'b1;
        pick_miss = miss;
        state_nxt = LOCKOUT;
      end
      LOCKOUT: if (lk_cnt == LK_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The button edge register runs in every state so a held button never looks like a new press.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      btn_prev      <= 1'b0;
      miss          <= 1'b0;
      k             <= 4'd0;
      pixel         <= 16'h0000;
      tmo_cnt       <= '0;
      lk_cnt        <= '0;
      fb_rd_addr    <= 13'd0;
      picked_index  <= 4'd0;
      picked_colour <= 16'h0000;
    end else begin
      btn_prev <= pick_btn;
      case (state)
        IDLE: begin
          if (trig) begin
            miss <= !in_range;
            if (in_range) fb_rd_addr <= addr_calc;
          end
        end
        REQ: tmo_cnt <= '0;
        WAIT: begin
          if (fb_rd_valid) begin
            pixel <= fb_rd_data;
            k     <= 4'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TO_LAST) miss <= 1'b1;
          end
        end
        SCAN: begin
          if (hit) begin
            picked_index  <= k;
            picked_colour <= palette(k);
          end else if (k == LAST_IDX) begin
            miss <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE:    lk_cnt <= '0;
        LOCKOUT: lk_cnt <= lk_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_colour_picker.sv
// Directed bench for colour_picker with a frame-buffer responder and a scoreboard of
// expected pick results checked on every pick_done pulse.
module tb_colour_picker;

  localparam int LK = 4;
  localparam int TO = 16;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        en;
  logic        pick_btn;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        fb_rd_en;
  logic [12:0] fb_rd_addr;
  logic [15:0] fb_rd_data;
  logic        fb_rd_valid;
  logic        busy;
  logic        pick_done;
  logic        pick_miss;
  logic [3:0]  picked_index;
  logic [15:0] picked_colour;

  colour_picker #(
    .LOCKOUT_CYCLES(LK),
    .TIMEOUT_CYCLES(TO),
    .WIDTH(96),
    .HEIGHT(64)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .en(en),
    .pick_btn(pick_btn),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .fb_rd_en(fb_rd_en),
    .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data),
    .fb_rd_valid(fb_rd_valid),
    .busy(busy),
    .pick_done(pick_done),
    .pick_miss(pick_miss),
    .picked_index(picked_index),
    .picked_colour(picked_colour)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic        miss;
    logic [3:0]  idx;
    logic [15:0] col;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pal [13] = '{16'h0000, 16'hFED3, 16'hFD46, 16'hC240, 16'hF800, 16'hCB5D,
                            16'h1619, 16'h2B58, 16'h0C8A, 16'h7687, 16'hFFCB, 16'h3FCF,
                            16'hC618};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_count = 0;
  int en_count = 0;
  int pending = 0;
  int mem_delay = 0;
  int last_done_cyc = 0;
  int last_en_cyc = 0;
  int last_valid_cyc = 0;
  int edge_cyc = 0;
  int d0 = 0;
  int e0 = 0;
  logic [12:0] last_addr = 13'd0;
  logic [15:0] mem_data = 16'h0000;
  logic [3:0]  exp_idx = 4'd0;
  logic [15:0] exp_col = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int lookup(input logic [15:0] d);
    for (int i = 0; i < 13; i++) if (pal[i] == d) return i;
    return 13;
  endfunction

  task automatic expect_miss();
    exp_t e;
    e.miss = 1'b1;
    e.idx  = exp_idx;
    e.col  = exp_col;
    sb.push_back(e);
  endtask

  task automatic expect_data(input logic [15:0] d);
    exp_t e;
    int   k;
    k = lookup(d);
    if (k < 13) begin
      exp_idx = 4'(k);
      exp_col = pal[k];
      e.miss  = 1'b0;
      e.idx   = exp_idx;
      e.col   = exp_col;
      sb.push_back(e);
    end else begin
      expect_miss();
    end
  endtask

  // One clock step: sample outputs after the edge, run the scoreboard and the frame-buffer model.
  task automatic tick();
    exp_t e;
    @(posedge CLOCK);
    #1;
    cyc++;
    fb_rd_valid = 1'b0;
    if (pick_done) begin
      done_count++;
      last_done_cyc = cyc;
      check("done_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pick_miss", pick_miss, e.miss);
        check("picked_index", picked_index, e.idx);
        check("picked_colour", picked_colour, e.col);
      end
    end else begin
      check("miss_without_done", pick_miss, 0);
    end
    if (fb_rd_en) begin
      en_count++;
      last_en_cyc = cyc;
      last_addr   = fb_rd_addr;
      if (mem_delay > 0) pending = mem_delay;
    end else if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        fb_rd_valid    = 1'b1;
        fb_rd_data     = mem_data;
        last_valid_cyc = cyc;
      end
    end
  endtask

  task automatic press(input int x, input int y);
    cursor_x = 7'(x);
    cursor_y = 6'(y);
    pick_btn = 1'b1;
    tick();
    edge_cyc = cyc;
    pick_btn = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_count;
    n = 0;
    while (done_count == start && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", done_count - start, 1);
  endtask

  initial begin
    RESET = 1'b1; en = 1'b1; pick_btn = 1'b0; cursor_x = 7'd0; cursor_y = 6'd0;
    fb_rd_data = 16'h0000; fb_rd_valid = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_fb_rd_en", fb_rd_en, 0);
    check("rst_pick_done", pick_done, 0);
    check("rst_pick_miss", pick_miss, 0);
    check("rst_index", picked_index, 0);
    check("rst_colour", picked_colour, 0);
    check("rst_addr", fb_rd_addr, 0);
    tick(); tick();
    RESET = 1'b0;
    tick();

    // RED at (10,20): match at k=4
    mem_delay = 2; mem_data = 16'hF800; d0 = done_count; e0 = en_count;
    expect_data(16'hF800);
    press(10, 20);
    check("red_addr", last_addr, 1930);
    check("red_strobe_cycle", last_en_cyc, edge_cyc);
    wait_idle(60);
    check("red_latency", last_done_cyc - last_valid_cyc, 6);
    check("red_one_strobe", en_count - e0, 1);
    check("red_one_done", done_count - d0, 1);

    // GREY: last palette entry, 13 compares after valid
    mem_data = 16'hC618; d0 = done_count;
    expect_data(16'hC618);
    press(95, 63);
    check("grey_addr", last_addr, 6143);
    wait_idle(60);
    check("grey_latency", last_done_cyc - last_valid_cyc, 14);
    check("grey_one_done", done_count - d0, 1);

    // no palette match keeps the previous index
    mem_data = 16'h1234; d0 = done_count;
    expect_data(16'h1234);
    press(0, 0);
    wait_idle(60);
    check("nomatch_one_done", done_count - d0, 1);

    // out-of-range cursor: no read, immediate miss
    d0 = done_count; e0 = en_count;
    expect_miss();
    press(96, 0);
    check("oor96_latency", last_done_cyc, edge_cyc);
    wait_idle(20);
    expect_miss();
    press(127, 5);
    check("oor127_latency", last_done_cyc, edge_cyc);
    wait_idle(20);
    check("oor_no_strobe", en_count - e0, 0);
    check("oor_done_count", done_count - d0, 2);

    // timeout, then a stray valid during lockout
    mem_delay = 0; d0 = done_count;
    expect_miss();
    press(3, 4);
    wait_done(40);
    check("timeout_latency", last_done_cyc - last_en_cyc, TO + 1);
    tick();
    fb_rd_valid = 1'b1; fb_rd_data = 16'hF800;
    tick();
    wait_idle(20);
    tick(); tick(); tick();
    check("stray_valid_done_count", done_count - d0, 1);
    check("stray_valid_index", picked_index, exp_idx);

    // edges during SCAN and LOCKOUT are dropped
    mem_delay = 2; mem_data = 16'hC618; d0 = done_count; e0 = en_count;
    expect_data(16'hC618);
    press(7, 7);
    tick(); tick(); tick(); tick();
    pick_btn = 1'b1; tick(); pick_btn = 1'b0;
    wait_done(30);
    tick();
    pick_btn = 1'b1; tick(); pick_btn = 1'b0;
    wait_idle(20);
    tick(); tick(); tick();
    check("dropped_done_count", done_count - d0, 1);
    check("dropped_strobe_count", en_count - e0, 1);

    // button held through lockout does not retrigger
    mem_data = 16'hF800; d0 = done_count;
    expect_data(16'hF800);
    cursor_x = 7'd1; cursor_y = 6'd2; pick_btn = 1'b1;
    tick();
    wait_idle(60);
    for (int i = 0; i < 6; i++) tick();
    check("held_done_count", done_count - d0, 1);
    pick_btn = 1'b0;
    tick();

    // disabled picker ignores the edge
    d0 = done_count; e0 = en_count; en = 1'b0;
    pick_btn = 1'b1; tick(); pick_btn = 1'b0;
    tick(); tick();
    check("disabled_busy", busy, 0);
    check("disabled_strobe", en_count - e0, 0);
    check("disabled_done", done_count - d0, 0);
    en = 1'b1;

    // en dropped mid-operation: completes normally
    mem_data = 16'h0C8A; d0 = done_count;
    expect_data(16'h0C8A);
    press(20, 10);
    en = 1'b0;
    wait_idle(60);
    check("en_drop_done", done_count - d0, 1);
    en = 1'b1;

    // reset while waiting for the frame buffer
    mem_delay = 0; e0 = en_count; d0 = done_count;
    press(5, 5);
    check("rst_wait_strobe", en_count - e0, 1);
    tick(); tick();
    RESET = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_fb_rd_en", fb_rd_en, 0);
    check("async_rst_pick_done", pick_done, 0);
    check("async_rst_index", picked_index, 0);
    tick();
    RESET = 1'b0;
    exp_idx = 4'd0; exp_col = 16'h0000;
    tick();
    check("rst_wait_no_done", done_count - d0, 0);

    // normal pick after reset
    mem_delay = 2; mem_data = 16'h2B58; d0 = done_count;
    expect_data(16'h2B58);
    press(0, 1);
    check("post_rst_addr", last_addr, 96);
    wait_idle(60);
    check("post_rst_done", done_count - d0, 1);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
